// File: rtl/spi_master_16.sv
// rtl/spi_master_16.sv - Avalon-MM register-mapped SPI master, mode 0, MSB first
module spi_master_16 #(
  parameter int DATABITS  = 16,
  parameter int DIV_HALF  = 195,
  parameter int NUMSLAVES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_select,
  input  logic [2:0]           mem_addr,
  input  logic                 read_n,
  input  logic                 write_n,
  input  logic [15:0]          data_from_cpu,
  output logic [15:0]          data_to_cpu,
  output logic                 irq,
  output logic                 dataavailable,
  output logic                 readyfordata,
  input  logic                 MISO,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic [NUMSLAVES-1:0] SS_n
);

  localparam int CW = $clog2(DIV_HALF);
  localparam int HW = $clog2(2 * DATABITS);
  localparam logic [15:0] CTRL_MASK = 16'h05D8;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state_q;
  logic [CW-1:0]         div_q, div_d;
  logic [HW-1:0]         hcnt_q;
  logic [DATABITS-1:0]   tx_hold_q, rx_hold_q, shift_q;
  logic [15:0]           ctrl_q, rdata_q, rdata_d, status;
  logic [NUMSLAVES-1:0]  ssel_q, ss_n_q;
  logic trdy_q, rrdy_q, toe_q, roe_q, gap_q, sclk_q, mosi_q, irq_q, irq_d;
  logic miso_s1_q, miso_s2_q;
  logic tick, wr, rd, sso, start_idle, start_hold, consume;

  assign wr  = spi_select & ~write_n;
  assign rd  = spi_select & ~read_n;
  assign sso = ctrl_q[10];

  // The divider only runs during a transfer or the inter-word SS_n gap.
  always_comb begin
    tick  = (div_q == CW'(DIV_HALF - 1));
    div_d = '0;
    if ((state_q != IDLE || gap_q) && !tick)
      div_d = div_q + CW'(1);
  end

  assign start_idle = (state_q == IDLE) && !gap_q && !trdy_q;
  assign start_hold = (state_q == HOLD) && tick && !trdy_q && sso;
  assign consume    = start_idle || start_hold;

  always_comb begin
    status  = {7'b0, toe_q | roe_q, rrdy_q, trdy_q, (state_q == IDLE) & trdy_q,
               toe_q, roe_q, 3'b0};
    irq_d   = ((toe_q | roe_q) & ctrl_q[8]) | (rrdy_q & ctrl_q[7]) |
              (trdy_q & ctrl_q[6]) | (toe_q & ctrl_q[4]) | (roe_q & ctrl_q[3]);
    rdata_d = '0;
    case (mem_addr)
      3'd0:    rdata_d = 16'(rx_hold_q);
      3'd2:    rdata_d = status;
      3'd3:    rdata_d = ctrl_q;
      3'd5:    rdata_d = 16'(ssel_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      hcnt_q    <= '0;
      tx_hold_q <= '0;
      rx_hold_q <= '0;
      shift_q   <= '0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      ssel_q    <= NUMSLAVES'(1);
      ss_n_q    <= '1;
      trdy_q    <= 1'b1;
      rrdy_q    <= 1'b0;
      toe_q     <= 1'b0;
      roe_q     <= 1'b0;
      gap_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      irq_q     <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;

      // Bus clears come first so that same-edge event sets below win.
      if (wr && mem_addr == 3'd2) begin
        toe_q  <= 1'b0;
        roe_q  <= 1'b0;
        rrdy_q <= 1'b0;
      end
      if (rd && mem_addr == 3'd0) rrdy_q <= 1'b0;
      if (wr && mem_addr == 3'd3) ctrl_q <= data_from_cpu & CTRL_MASK;
      if (wr && mem_addr == 3'd5) ssel_q <= data_from_cpu[NUMSLAVES-1:0];

      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          if (gap_q && tick) gap_q <= 1'b0;
          if (!sso) ss_n_q <= '1;
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            hcnt_q <= hcnt_q + HW'(1);
            // MISO is captured at the end of the SCLK-high phase so the
            // synchronizer latency is covered even at DIV_HALF=2.
            if (!hcnt_q[0]) begin
              sclk_q  <= 1'b0;
              shift_q <= {shift_q[DATABITS-2:0], miso_s2_q};
              if (hcnt_q != HW'(2 * DATABITS - 2)) mosi_q <= shift_q[DATABITS-2];
            end else if (hcnt_q == HW'(2 * DATABITS - 1)) begin
              state_q <= HOLD;
              if (rrdy_q) roe_q <= 1'b1;
              else        rx_hold_q <= shift_q;
              rrdy_q  <= 1'b1;
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (!sso) ss_n_q <= '1;
            if (!trdy_q && !sso) gap_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (consume) begin
        state_q <= SETUP;
        shift_q <= tx_hold_q;
        trdy_q  <= 1'b1;
        ss_n_q  <= ~ssel_q;
        mosi_q  <= tx_hold_q[DATABITS-1];
        hcnt_q  <= '0;
      end

      if (wr && mem_addr == 3'd1) begin
        if (trdy_q || consume) begin
          tx_hold_q <= data_from_cpu[DATABITS-1:0];
          trdy_q    <= 1'b0;
        end else begin
          toe_q <= 1'b1;
        end
      end
    end
  end

  assign data_to_cpu   = rdata_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy_q;
  assign SCLK          = sclk_q;
  assign MOSI          = mosi_q;
  assign SS_n          = ss_n_q;

endmodule

// File: tb/tb_spi_master_16.sv
// tb/tb_spi_master_16.sv - directed vector bench for spi_master_16 at DIV_HALF=2
module tb_spi_master_16;
  localparam int DH = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0]  mem_addr = '0;
  logic [15:0] data_from_cpu = '0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata, MISO, SCLK, MOSI;
  logic [0:0]  SS_n;

  logic        loop_en = 1'b1;
  logic [15:0] slave_word = 16'h3C0F, s_rx = '0;
  int          s_fall = 0;
  logic        slave_miso;

  int n_tests = 0, n_fail = 0;

  assign slave_miso = (s_fall < 16) ? slave_word[4'(15 - s_fall)] : 1'b0;
  assign MISO = loop_en ? MOSI : slave_miso;

  spi_master_16 #(.DATABITS(16), .DIV_HALF(DH), .NUMSLAVES(1)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  // Model slave: shifts its word out on falling SCLK, captures MOSI on rising.
  always @(negedge SCLK or posedge SS_n[0]) begin
    if (SS_n[0]) s_fall <= 0;
    else         s_fall <= s_fall + 1;
  end
  always @(posedge SCLK) if (!SS_n[0]) s_rx <= {s_rx[14:0], MOSI};

  logic mon_en = 1'b0, sclk_prev = 1'b0, mosi_prev = 1'b0;
  int   rises = 0, ss_high = 0, mosi_bad = 0;
  always @(negedge clk) begin
    sclk_prev <= SCLK;
    mosi_prev <= MOSI;
    if (!mon_en) begin
      rises <= 0; ss_high <= 0; mosi_bad <= 0;
    end else begin
      if (SCLK && !sclk_prev) rises <= rises + 1;
      if (MOSI !== mosi_prev && SCLK) mosi_bad <= mosi_bad + 1;
      if (SS_n[0] && rises >= 1 && rises < 32) ss_high <= ss_high + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(posedge clk); #1;
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic write_pair(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    spi_select = 1'b1; write_n = 1'b0; mem_addr = 3'd1; data_from_cpu = a;
    @(posedge clk); #1;
    data_from_cpu = b;
    @(posedge clk); #1;
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(posedge clk); #1;
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_rrdy(input string name, input int budget);
    for (int i = 0; i < budget && !dataavailable; i++) begin
      @(posedge clk); #1;
    end
    check({name, " rrdy"}, 32'(dataavailable), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t        vecs[11];
  logic [15:0] rd;
  int          ss_cyc, rise0, rrdy_cyc, nrise, per_bad, prev_rise;
  logic        prev_sclk;

  initial begin
    vecs[0]  = '{1'b0, 3'd2, 16'h0000, 16'h0060, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd5, 16'h0000, 16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 16'hFFFF, 16'h05D8, 1'b1};
    vecs[5]  = '{1'b1, 3'd3, 16'h0040, 16'h0040, 1'b1};
    vecs[6]  = '{1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 3'd5, 16'hFFFE, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 3'd5, 16'h0001, 16'h0001, 1'b0};
    vecs[9]  = '{1'b1, 3'd4, 16'h1234, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 16'hFFFF, 16'h0060, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset data_to_cpu", 32'(data_to_cpu), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset SS_n", 32'(SS_n), 32'h1);
    check("reset SCLK", 32'(SCLK), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("vec%0d rd", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Loopback timing, cycles counted from the txdata write edge.
    loop_en = 1'b1;
    bus_write(3'd1, 16'hA5C3);
    ss_cyc = -1; rise0 = -1; rrdy_cyc = -1; nrise = 0; per_bad = 0; prev_rise = -1;
    prev_sclk = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (!SS_n[0] && ss_cyc < 0) ss_cyc = c;
      if (SCLK && !prev_sclk) begin
        if (prev_rise >= 0 && c - prev_rise != 2 * DH) per_bad++;
        if (nrise == 0) rise0 = c;
        prev_rise = c;
        nrise++;
      end
      prev_sclk = SCLK;
      if (dataavailable && rrdy_cyc < 0) rrdy_cyc = c;
    end
    check("lb ss_low cycle", 32'(ss_cyc), 32'd1);
    check("lb first rise", 32'(rise0), 32'(1 + DH));
    check("lb sclk pulses", 32'(nrise), 32'd16);
    check("lb sclk period", 32'(per_bad), 32'd0);
    check("lb rrdy cycle", 32'(rrdy_cyc), 32'(ss_cyc + 66));
    check("lb ss_n end", 32'(SS_n), 32'h1);
    bus_read(3'd0, rd);
    check("lb rxdata", 32'(rd), 32'hA5C3);
    check("lb rrdy cleared", 32'(dataavailable), 32'd0);

    loop_en = 1'b0;
    slave_word = 16'h3C0F;
    mon_en = 1'b1;
    bus_write(3'd1, 16'h1234);
    wait_rrdy("slave", 200);
    repeat (4) @(posedge clk);
    check("slave saw", 32'(s_rx), 32'h1234);
    check("slave mosi edge", 32'(mosi_bad), 32'd0);
    bus_read(3'd0, rd);
    check("slave rxdata", 32'(rd), 32'h3C0F);
    mon_en = 1'b0;
    loop_en = 1'b1;
    repeat (4) @(posedge clk);

    bus_write(3'd1, 16'h1111);
    bus_write(3'd1, 16'h2222);
    bus_read(3'd2, rd);
    check("ovr second accepted", 32'(rd), 32'h0000);
    bus_write(3'd1, 16'h3333);
    bus_read(3'd2, rd);
    check("ovr toe", 32'(rd), 32'h0110);
    wait_rrdy("ovr word1", 200);
    rd = '0;
    for (int i = 0; i < 100 && !rd[3]; i++) bus_read(3'd2, rd);
    check("ovr roe seen", 32'(rd[3]), 32'd1);
    repeat (10) @(posedge clk);
    bus_read(3'd2, rd);
    check("ovr status idle", 32'(rd), 32'h01F8);
    bus_read(3'd0, rd);
    check("ovr rx kept", 32'(rd), 32'h1111);
    bus_write(3'd2, 16'h0000);
    bus_read(3'd2, rd);
    check("ovr status clr", 32'(rd), 32'h0060);

    // Write landing on the same edge that IDLE consumes the holding register.
    write_pair(16'h0F0F, 16'hF00F);
    bus_read(3'd2, rd);
    check("simul no toe", 32'(rd), 32'h0000);
    wait_rrdy("simul w1", 200);
    bus_read(3'd0, rd);
    check("simul rx1", 32'(rd), 32'h0F0F);
    wait_rrdy("simul w2", 200);
    bus_read(3'd0, rd);
    check("simul rx2", 32'(rd), 32'hF00F);
    repeat (6) @(posedge clk);

    bus_write(3'd3, 16'h0400);
    mon_en = 1'b1;
    bus_write(3'd1, 16'h0001);
    bus_write(3'd1, 16'h8000);
    wait_rrdy("sso w1", 200);
    bus_read(3'd0, rd);
    check("sso rx1", 32'(rd), 32'h0001);
    wait_rrdy("sso w2", 200);
    bus_read(3'd0, rd);
    check("sso rx2", 32'(rd), 32'h8000);
    repeat (8) @(posedge clk);
    check("sso rises", 32'(rises), 32'd32);
    check("sso ss held", 32'(ss_high), 32'd0);
    check("sso ss low after", 32'(SS_n), 32'h0);
    mon_en = 1'b0;
    bus_write(3'd3, 16'h0000);
    @(posedge clk); #1;
    check("sso clear deassert", 32'(SS_n), 32'h1);
    repeat (2) @(posedge clk);

    mon_en = 1'b1;
    bus_write(3'd1, 16'h0001);
    bus_write(3'd1, 16'h8000);
    wait_rrdy("nosso w1", 200);
    bus_read(3'd0, rd);
    wait_rrdy("nosso w2", 200);
    bus_read(3'd0, rd);
    repeat (8) @(posedge clk);
    check("nosso rises", 32'(rises), 32'd32);
    check("nosso gap>=half", 32'(ss_high >= DH), 32'd1);
    mon_en = 1'b0;

    bus_write(3'd3, 16'h0080);
    bus_write(3'd1, 16'hBEEF);
    for (int i = 0; i < 200 && !dataavailable; i++) begin
      @(posedge clk); #1;
    end
    check("irq rrdy seen", 32'(dataavailable), 32'd1);
    check("irq lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq set", 32'(irq), 32'd1);
    bus_read(3'd0, rd);
    check("irq rx", 32'(rd), 32'hBEEF);
    @(posedge clk); #1;
    check("irq cleared", 32'(irq), 32'd0);
    bus_write(3'd3, 16'h0000);

    bus_write(3'd1, 16'h5555);
    repeat (20) @(posedge clk);
    #2;
    check("rst mid ss low", 32'(SS_n), 32'h0);
    reset_n = 1'b0;
    #1;
    check("rst SCLK", 32'(SCLK), 32'h0);
    check("rst SS_n", 32'(SS_n), 32'h1);
    check("rst TRDY", 32'(readyfordata), 32'd1);
    #10 reset_n = 1'b1;
    bus_read(3'd2, rd);
    check("rst status", 32'(rd), 32'h0060);
    bus_read(3'd0, rd);
    check("rst rxdata", 32'(rd), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
